// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - shadow-pipe hazard detector producing stall/bubble for load-use and jalr hazards
// Optional macro HAZARD_STATS_EN adds a 16-bit saturating stall-cycle counter output StallCount_o.
module hazard_tracker #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] RS1addr_ID_i,
  input  logic [REG_ADDR_W-1:0] RS2addr_ID_i,
  input  logic                  UsesRS2_ID_i,
  input  logic                  Jalr_ID_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_ID_i,
  input  logic                  RegWrite_ID_i,
  input  logic                  MemRead_ID_i,
  input  logic                  Flush_i,
  output logic [REG_ADDR_W-1:0] RDaddr_IDEX_o,
  output logic                  RegWrite_IDEX_o,
  output logic                  MemRead_IDEX_o,
  output logic [REG_ADDR_W-1:0] RDaddr_EXMEM_o,
  output logic                  RegWrite_EXMEM_o,
  output logic                  MemRead_EXMEM_o,
  output logic [REG_ADDR_W-1:0] RDaddr_MEMWB_o,
  output logic                  RegWrite_MEMWB_o,
  output logic                  Stall_o,
  output logic                  Bubble_o,
`ifdef HAZARD_STATS_EN
  output logic [15:0]           StallCount_o,
`endif
  output logic                  Err_o
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  logic [REG_ADDR_W-1:0] idexRdQ, exmemRdQ, memwbRdQ;
  logic                  idexRegWriteQ, idexMemReadQ;
  logic                  exmemRegWriteQ, exmemMemReadQ;
  logic                  memwbRegWriteQ;

  state_t     stateQ, stateD;
  logic [1:0] cntQ, cntD;
  logic       errQ, errD;

  logic       loadUse, jalrEx, jalrMem, stall;

  // Hazard detection against the shadow ID/EX and EX/MEM destinations; x0 never hazards
  always_comb begin
    loadUse = idexMemReadQ && (idexRdQ != '0) &&
              ((idexRdQ == RS1addr_ID_i) || (UsesRS2_ID_i && (idexRdQ == RS2addr_ID_i)));
    jalrEx  = Jalr_ID_i && idexRegWriteQ && (idexRdQ != '0) && (idexRdQ == RS1addr_ID_i);
    jalrMem = Jalr_ID_i && exmemMemReadQ && (exmemRdQ != '0) && (exmemRdQ == RS1addr_ID_i);
    // A taken branch squashes the ID instruction, so its hazards are moot
    stall   = (loadUse || jalrEx || jalrMem) && !Flush_i;
  end

  assign Stall_o  = stall;
  assign Bubble_o = stall;

  // Shadow pipe always advances; ID/EX takes a NOP on bubble or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idexRdQ        <= '0;
      idexRegWriteQ  <= 1'b0;
      idexMemReadQ   <= 1'b0;
      exmemRdQ       <= '0;
      exmemRegWriteQ <= 1'b0;
      exmemMemReadQ  <= 1'b0;
      memwbRdQ       <= '0;
      memwbRegWriteQ <= 1'b0;
    end else begin
      if (stall || Flush_i) begin
        idexRdQ       <= '0;
        idexRegWriteQ <= 1'b0;
        idexMemReadQ  <= 1'b0;
      end else begin
        idexRdQ       <= RDaddr_ID_i;
        idexRegWriteQ <= RegWrite_ID_i;
        idexMemReadQ  <= MemRead_ID_i;
      end
      exmemRdQ       <= idexRdQ;
      exmemRegWriteQ <= idexRegWriteQ;
      exmemMemReadQ  <= idexMemReadQ;
      memwbRdQ       <= exmemRdQ;
      memwbRegWriteQ <= exmemRegWriteQ;
    end
  end

  assign RDaddr_IDEX_o    = idexRdQ;
  assign RegWrite_IDEX_o  = idexRegWriteQ;
  assign MemRead_IDEX_o   = idexMemReadQ;
  assign RDaddr_EXMEM_o   = exmemRdQ;
  assign RegWrite_EXMEM_o = exmemRegWriteQ;
  assign MemRead_EXMEM_o  = exmemMemReadQ;
  assign RDaddr_MEMWB_o   = memwbRdQ;
  assign RegWrite_MEMWB_o = memwbRegWriteQ;

  // Stall-tracking FSM state, consecutive-stall counter and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ <= RUN;
      cntQ   <= 2'd0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      errQ   <= errD;
    end
  end

  // Next state: counter holds the number of consecutive stall cycles already taken
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    errD   = errQ;
    case (stateQ)
      RUN: begin
        cntD = stall ? 2'd1 : 2'd0;
        if (stall) stateD = STALL;
      end
      STALL: begin
        if (stall) begin
          cntD = (cntQ == 2'd3) ? 2'd3 : cntQ + 2'd1;
        end else begin
          cntD   = 2'd0;
          stateD = RUN;
        end
      end
      default: begin
        stateD = RUN;
        cntD   = 2'd0;
      end
    endcase
    // A third back-to-back stall cycle means the pipe is wedged
    if (stall && (cntQ == 2'd2)) errD = 1'b1;
  end

  assign Err_o = errQ;

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCountQ;

  // Saturating count of all stall cycles since reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCountQ <= 16'd0;
    end else if (stall && (stallCountQ != 16'hFFFF)) begin
      stallCountQ <= stallCountQ + 16'd1;
    end
  end

  assign StallCount_o = stallCountQ;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - table-driven bench for hazard_tracker
module tb_hazard_tracker;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] RS1addr_ID_i, RS2addr_ID_i, RDaddr_ID_i;
  logic       UsesRS2_ID_i, Jalr_ID_i, RegWrite_ID_i, MemRead_ID_i, Flush_i;
  logic [4:0] RDaddr_IDEX_o, RDaddr_EXMEM_o, RDaddr_MEMWB_o;
  logic       RegWrite_IDEX_o, MemRead_IDEX_o, RegWrite_EXMEM_o, MemRead_EXMEM_o, RegWrite_MEMWB_o;
  logic       Stall_o, Bubble_o, Err_o;
`ifdef HAZARD_STATS_EN
  logic [15:0] StallCount_o;
`endif

  int checks = 0;
  int failures = 0;

  hazard_tracker #(.REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RS1addr_ID_i(RS1addr_ID_i), .RS2addr_ID_i(RS2addr_ID_i),
    .UsesRS2_ID_i(UsesRS2_ID_i), .Jalr_ID_i(Jalr_ID_i),
    .RDaddr_ID_i(RDaddr_ID_i), .RegWrite_ID_i(RegWrite_ID_i), .MemRead_ID_i(MemRead_ID_i),
    .Flush_i(Flush_i),
    .RDaddr_IDEX_o(RDaddr_IDEX_o), .RegWrite_IDEX_o(RegWrite_IDEX_o), .MemRead_IDEX_o(MemRead_IDEX_o),
    .RDaddr_EXMEM_o(RDaddr_EXMEM_o), .RegWrite_EXMEM_o(RegWrite_EXMEM_o), .MemRead_EXMEM_o(MemRead_EXMEM_o),
    .RDaddr_MEMWB_o(RDaddr_MEMWB_o), .RegWrite_MEMWB_o(RegWrite_MEMWB_o),
    .Stall_o(Stall_o), .Bubble_o(Bubble_o),
`ifdef HAZARD_STATS_EN
    .StallCount_o(StallCount_o),
`endif
    .Err_o(Err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       uses, jalr;
    logic [4:0] rd;
    logic       rw, mr, flush;
    logic       expStall;
    logic [6:0] expIdex;   // {rd, regWrite, memRead}
    logic [6:0] expExmem;  // {rd, regWrite, memRead}
    logic [5:0] expMemwb;  // {rd, regWrite}
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                              input logic jalr, input logic [4:0] rd, input logic rw, input logic mr,
                              input logic flush, input logic st, input logic [6:0] idex,
                              input logic [6:0] exmem, input logic [5:0] memwb);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.uses = uses; v.jalr = jalr; v.rd = rd; v.rw = rw; v.mr = mr;
    v.flush = flush; v.expStall = st; v.expIdex = idex; v.expExmem = exmem; v.expMemwb = memwb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                       input logic jalr, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic flush);
    RS1addr_ID_i = rs1; RS2addr_ID_i = rs2; UsesRS2_ID_i = uses; Jalr_ID_i = jalr;
    RDaddr_ID_i = rd; RegWrite_ID_i = rw; MemRead_ID_i = mr; Flush_i = flush;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_stall"}, {31'd0, Stall_o}, 32'd0);
    check({tag, "_bubble"}, {31'd0, Bubble_o}, 32'd0);
    check({tag, "_idex"}, {25'd0, RDaddr_IDEX_o, RegWrite_IDEX_o, MemRead_IDEX_o}, 32'd0);
    check({tag, "_exmem"}, {25'd0, RDaddr_EXMEM_o, RegWrite_EXMEM_o, MemRead_EXMEM_o}, 32'd0);
    check({tag, "_memwb"}, {26'd0, RDaddr_MEMWB_o, RegWrite_MEMWB_o}, 32'd0);
    check({tag, "_err"}, {31'd0, Err_o}, 32'd0);
  endtask

  initial begin
    //                rs1 rs2 u  j  rd  rw mr fl  st  idex         exmem        memwb
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, {5'd0,2'b00}, {5'd0,2'b00}, {5'd0,1'b0}); // nop
    vecs[1]  = mk(2, 0, 0, 0, 5, 1, 1, 0, 0, {5'd0,2'b00}, {5'd0,2'b00}, {5'd0,1'b0}); // lw x5
    vecs[2]  = mk(5, 7, 1, 0, 6, 1, 0, 0, 1, {5'd5,2'b11}, {5'd0,2'b00}, {5'd0,1'b0}); // add x6,x5,x7 stalls
    vecs[3]  = mk(5, 7, 1, 0, 6, 1, 0, 0, 0, {5'd0,2'b00}, {5'd5,2'b11}, {5'd0,1'b0}); // add held, bubble seen
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, {5'd6,2'b10}, {5'd0,2'b00}, {5'd5,1'b1}); // add in IDEX
    vecs[5]  = mk(0, 0, 0, 0, 3, 1, 0, 0, 0, {5'd0,2'b00}, {5'd6,2'b10}, {5'd0,1'b0}); // addi x3
    vecs[6]  = mk(3, 0, 0, 1, 1, 1, 0, 0, 1, {5'd3,2'b10}, {5'd0,2'b00}, {5'd6,1'b1}); // jalr via x3: H2
    vecs[7]  = mk(3, 0, 0, 1, 1, 1, 0, 0, 0, {5'd0,2'b00}, {5'd3,2'b10}, {5'd0,1'b0}); // proceeds, EXMEM=3
    vecs[8]  = mk(2, 0, 0, 0, 3, 1, 1, 0, 0, {5'd1,2'b10}, {5'd0,2'b00}, {5'd3,1'b1}); // lw x3
    vecs[9]  = mk(3, 0, 0, 1, 1, 1, 0, 0, 1, {5'd3,2'b11}, {5'd1,2'b10}, {5'd0,1'b0}); // jalr: H1/H2
    vecs[10] = mk(3, 0, 0, 1, 1, 1, 0, 0, 1, {5'd0,2'b00}, {5'd3,2'b11}, {5'd1,1'b1}); // jalr: H3
    vecs[11] = mk(3, 0, 0, 1, 1, 1, 0, 0, 0, {5'd0,2'b00}, {5'd0,2'b00}, {5'd3,1'b1}); // jalr proceeds
    vecs[12] = mk(2, 0, 0, 0, 4, 1, 1, 0, 0, {5'd1,2'b10}, {5'd0,2'b00}, {5'd0,1'b0}); // lw x4
    vecs[13] = mk(4, 4, 1, 0, 6, 1, 0, 1, 0, {5'd4,2'b11}, {5'd1,2'b10}, {5'd0,1'b0}); // hazard + flush
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, {5'd0,2'b00}, {5'd4,2'b11}, {5'd1,1'b1}); // lw x0, IDEX flushed
    vecs[15] = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, {5'd0,2'b11}, {5'd0,2'b00}, {5'd4,1'b1}); // x0 dest: no hazard
    vecs[16] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, {5'd1,2'b10}, {5'd0,2'b11}, {5'd0,1'b0}); // x0 in EXMEM: no H3
    vecs[17] = mk(0, 0, 0, 0, 9, 1, 1, 0, 0, {5'd1,2'b10}, {5'd1,2'b10}, {5'd0,1'b1}); // lw x9
    vecs[18] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, {5'd9,2'b11}, {5'd1,2'b10}, {5'd1,1'b1}); // rs2 unused: no stall
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, {5'd0,2'b00}, {5'd9,2'b11}, {5'd1,1'b1}); // nop

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkAllZero("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].uses, vecs[i].jalr, vecs[i].rd,
            vecs[i].rw, vecs[i].mr, vecs[i].flush);
      @(negedge clk_i);
      check($sformatf("v%0d_stall", i), {31'd0, Stall_o}, {31'd0, vecs[i].expStall});
      check($sformatf("v%0d_bubble", i), {31'd0, Bubble_o}, {31'd0, vecs[i].expStall});
      check($sformatf("v%0d_idex", i), {25'd0, RDaddr_IDEX_o, RegWrite_IDEX_o, MemRead_IDEX_o},
            {25'd0, vecs[i].expIdex});
      check($sformatf("v%0d_exmem", i), {25'd0, RDaddr_EXMEM_o, RegWrite_EXMEM_o, MemRead_EXMEM_o},
            {25'd0, vecs[i].expExmem});
      check($sformatf("v%0d_memwb", i), {26'd0, RDaddr_MEMWB_o, RegWrite_MEMWB_o},
            {26'd0, vecs[i].expMemwb});
      check($sformatf("v%0d_err", i), {31'd0, Err_o}, 32'd0);
      @(posedge clk_i);
      #1;
    end

    // Reset pulsed in the middle of a load-use stall, away from any clock edge
    drive(2, 0, 0, 0, 5, 1, 1, 0);
    @(posedge clk_i);
    #1;
    drive(5, 7, 1, 0, 6, 1, 0, 0);
    @(negedge clk_i);
    check("midrst_pre_stall", {31'd0, Stall_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    checkAllZero("midrst");
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("postrst_stall", {31'd0, Stall_o}, 32'd0);
    check("postrst_idex_rd", {27'd0, RDaddr_IDEX_o}, 32'd6);

    // H1 forced for three consecutive cycles to reach the sticky error
    drive(5, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    force dut.idexRdQ = 5'd5;
    force dut.idexRegWriteQ = 1'b1;
    force dut.idexMemReadQ = 1'b1;
    @(negedge clk_i);
    check("forced_stall", {31'd0, Stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    check("err_edge1", {31'd0, Err_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("err_edge2", {31'd0, Err_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("err_edge3", {31'd0, Err_o}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    release dut.idexRdQ;
    release dut.idexRegWriteQ;
    release dut.idexMemReadQ;
    repeat (2) @(posedge clk_i);
    #1;
    check("err_sticky", {31'd0, Err_o}, 32'd1);
    check("stall_after_release", {31'd0, Stall_o}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("stall_count", {16'd0, StallCount_o}, 32'd3);
`endif
    rst_i = 1'b1;
    #1;
    check("err_cleared", {31'd0, Err_o}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("stall_count_cleared", {16'd0, StallCount_o}, 32'd0);
`endif
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-address width.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset; asynchronous, active-high.
REQ-004 RS1addr_ID_i / RS2addr_ID_i  in  REG_ADDR_W  source registers of the instruction in ID.
REQ-005 UsesRS2_ID_i  in  1  ID instruction reads rs2.
REQ-006 Jalr_ID_i  in  1  ID instruction is jalr; its rs1 is consumed in ID.
REQ-007 RDaddr_ID_i, RegWrite_ID_i, MemRead_ID_i  in  REG_ADDR_W/1/1  destination info of the ID instruction.
REQ-008 Flush_i  in  1  taken branch resolved in EX; the ID instruction is wrong-path.
REQ-009 RDaddr_IDEX_o, RegWrite_IDEX_o, MemRead_IDEX_o  out  REG_ADDR_W/1/1  shadow ID/EX destination info.
REQ-010 RDaddr_EXMEM_o, RegWrite_EXMEM_o, MemRead_EXMEM_o  out  REG_ADDR_W/1/1  shadow EX/MEM info; feeds the forwarding unit.
REQ-011 RDaddr_MEMWB_o, RegWrite_MEMWB_o  out  REG_ADDR_W/1  shadow MEM/WB info; feeds the forwarding unit.
REQ-012 Stall_o  out  1  hold PC and IF/ID this cycle.
REQ-013 Bubble_o  out  1  insert NOP into ID/EX this cycle.
REQ-014 Err_o  out  1  sticky: stall exceeded 2 consecutive cycles.

Function
REQ-015 Shadow pipe SHALL advance every cycle: IDEX<=ID inputs, EXMEM<=IDEX, MEMWB<=EXMEM; stalls do not hold EXMEM/MEMWB.
REQ-016 When Bubble_o=1 or Flush_i=1, IDEX SHALL load RD=0, RegWrite=0, MemRead=0.
REQ-017 Load-use hazard (H1): MemRead_IDEX_o & RDaddr_IDEX_o!=0 & (RDaddr_IDEX_o==RS1addr_ID_i | (UsesRS2_ID_i & RDaddr_IDEX_o==RS2addr_ID_i)).
REQ-018 Jalr-EX hazard (H2): Jalr_ID_i & RegWrite_IDEX_o & RDaddr_IDEX_o!=0 & RDaddr_IDEX_o==RS1addr_ID_i.
REQ-019 Jalr-load-MEM hazard (H3): Jalr_ID_i & MemRead_EXMEM_o & RDaddr_EXMEM_o!=0 & RDaddr_EXMEM_o==RS1addr_ID_i.
REQ-020 Stall_o SHALL be combinational = (H1|H2|H3) & ~Flush_i; Bubble_o SHALL equal Stall_o.
REQ-021 Resulting stall lengths: ALU producer -> jalr: 1 cycle; load producer -> jalr: 2 cycles; load producer -> non-jalr consumer: 1 cycle.
REQ-022 Flush_i SHALL take priority over every hazard in the same cycle.
REQ-023 FSM states RUN, STALL; RUN->STALL on Stall_o=1; STALL->RUN on Stall_o=0; a 2-bit saturating consecutive-stall counter clears in RUN and increments in STALL.
REQ-024 Err_o SHALL set on the edge where the counter is 2 and Stall_o=1 (third consecutive stall cycle), and hold until reset.
REQ-025 Register x0 (address 0) SHALL never cause a hazard.

Reset
REQ-026 On rst_i=1 all shadow fields, the FSM (RUN), the counter, and Err_o SHALL clear to 0 immediately, independent of clk_i.
REQ-027 Therefore Stall_o=Bubble_o=0 during and directly after reset; reset asserted mid-stall aborts the stall in the same cycle.

Configuration
REQ-028 Macro HAZARD_STATS_EN: when defined, adds output StallCount_o (16 bits), incremented on each cycle with Stall_o=1, saturating at 0xFFFF, cleared by reset.
REQ-029 Without HAZARD_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Load x5 in ID, then add x6,x5,x7 -> Stall_o=1 for exactly 1 cycle; IDEX shows RD=0 that cycle, then RD=6.
REQ-031 addi x3 followed by jalr x1,0(x3) -> 1 stall cycle; jalr proceeds when RDaddr_EXMEM_o=3.
REQ-032 lw x3 followed by jalr via x3 -> 2 stall cycles (H2 then H3); Err_o stays 0.
REQ-033 Hazard condition and Flush_i=1 in the same cycle -> Stall_o=0, IDEX cleared.
REQ-034 Destination x0 with load and matching rs1=0 -> Stall_o=0; rst_i pulsed mid-stall -> all outputs 0 asynchronously.
REQ-035 Forced H1 held for 3 cycles -> Err_o=1 from the 3rd edge onward; with HAZARD_STATS_EN, StallCount_o=3.
